tl_ram_device: RTL and testbench

// - TileLink-UH device endpoint: single-ported on-chip RAM that answers the host's A channel on the D channel.
// - Serves Get, PutFullData and PutPartialData, single- and multi-beat. Answers every other A opcode with a denied response.
// - Sits behind a tl_channel device modport (A/D wired flat here). B/C/E are not used.

---
 rtl/tl_ram_device.sv | 204 ++++++++++++++++++++
 tb/tb_tl_ram_device.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/tl_ram_device.sv
// tl_ram_device: TileLink-UH RAM endpoint; serves Get/PutFull/PutPartial bursts, denies other opcodes.
// Optional macro TL_RAM_DEVICE_ALIGN_CHECK_EN: deny requests whose address is not aligned to 2**a_size.
package tl_ram_device_pkg;
    typedef enum logic [2:0] {
        PutFullData    = 3'd0,
        PutPartialData = 3'd1,
        ArithmeticData = 3'd2,
        LogicalData    = 3'd3,
        Get            = 3'd4,
        Intent         = 3'd5,
        AcquireBlock   = 3'd6,
        AcquirePerm    = 3'd7
    } tl_a_op_e;

    typedef enum logic [2:0] {
        AccessAck     = 3'd0,
        AccessAckData = 3'd1,
        HintAck       = 3'd2,
        Grant         = 3'd4,
        GrantData     = 3'd5,
        ReleaseAck    = 3'd6
    } tl_d_op_e;
endpackage

module tl_ram_device
    import tl_ram_device_pkg::*;
#(
    parameter int SourceWidth = 1,
    parameter int SinkWidth   = 1,
    parameter int AddrWidth   = 56,
    parameter int DataWidth   = 64,
    parameter int SizeWidth   = 3,
    parameter int DepthLog2   = 10
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   a_valid,
    output logic                   a_ready,
    input  tl_a_op_e               a_opcode,
    input  logic [2:0]             a_param,
    input  logic [SizeWidth-1:0]   a_size,
    input  logic [SourceWidth-1:0] a_source,
    input  logic [AddrWidth-1:0]   a_address,
    input  logic [DataWidth/8-1:0] a_mask,
    input  logic                   a_corrupt,
    input  logic [DataWidth-1:0]   a_data,
    output logic                   d_valid,
    input  logic                   d_ready,
    output tl_d_op_e               d_opcode,
    output logic [2:0]             d_param,
    output logic [SizeWidth-1:0]   d_size,
    output logic [SourceWidth-1:0] d_source,
    output logic [SinkWidth-1:0]   d_sink,
    output logic                   d_denied,
    output logic                   d_corrupt,
    output logic [DataWidth-1:0]   d_data
);
    localparam int OffW  = $clog2(DataWidth / 8);
    localparam int MaxSh = ((2 ** SizeWidth) - 1 > OffW) ? (2 ** SizeWidth) - 1 - OffW : 0;
    localparam int CntW  = (MaxSh > 0) ? MaxSh : 1;

    typedef enum logic [1:0] {IDLE, WRITE, READ, RESP} state_e;

    state_e                 state_q;
    logic [CntW-1:0]        cnt_q, nlast_q, a_nlast;
    logic [DepthLog2-1:0]   base_q, a_idx, wr_idx, rd_idx;
    logic                   put_q, rdresp_q;
    logic                   d_valid_q, d_denied_q, d_corrupt_q;
    tl_d_op_e               d_opcode_q;
    logic [SizeWidth-1:0]   d_size_q;
    logic [SourceWidth-1:0] d_source_q;

    logic [DataWidth-1:0]   mem [2**DepthLog2];
    logic [DataWidth-1:0]   rdata_q;

    logic a_put, a_get, a_atom, a_intent, a_deny, a_fire, d_fire, last_beat;
    logic wr_en, rd_en;

    assign a_put    = (a_opcode == PutFullData) || (a_opcode == PutPartialData);
    assign a_get    = (a_opcode == Get);
    assign a_atom   = (a_opcode == ArithmeticData) || (a_opcode == LogicalData);
    assign a_intent = !(a_put || a_get || a_atom);

`ifdef TL_RAM_DEVICE_ALIGN_CHECK_EN
    logic a_misal;
    always_comb begin
        a_misal = 1'b0;
        for (int i = 0; i < AddrWidth; i++)
            if (i < int'(a_size) && a_address[i]) a_misal = 1'b1;
    end
    assign a_deny = !(a_put || a_get) || a_misal;
`else
    assign a_deny = !(a_put || a_get);
`endif

    // Beats minus one: bit i set when the transfer spans more than 2**i beats.
    always_comb begin
        a_nlast = '0;
        for (int i = 0; i < CntW; i++)
            if (int'(a_size) > OffW + i) a_nlast[i] = 1'b1;
    end

    assign a_idx     = a_address[OffW +: DepthLog2];
    assign a_ready   = (state_q == IDLE) || (state_q == WRITE);
    assign a_fire    = a_valid && a_ready;
    assign d_fire    = d_valid_q && d_ready;
    assign last_beat = (cnt_q == nlast_q);

    assign wr_en  = a_fire && !a_corrupt &&
                    ((state_q == IDLE)  ? (a_put && !a_deny) :
                     (state_q == WRITE) ? (put_q && !d_denied_q) : 1'b0);
    assign wr_idx = (state_q == IDLE) ? a_idx : base_q + DepthLog2'(cnt_q);
    // Next beat is fetched as the current one leaves, so d_data holds during stalls.
    assign rd_en  = ((state_q == IDLE) && a_fire && a_get) ||
                    ((state_q == READ) && d_fire && !last_beat);
    assign rd_idx = (state_q == IDLE) ? a_idx : base_q + DepthLog2'(cnt_q) + DepthLog2'(1);

    always_ff @(posedge clk_i) begin
        if (wr_en)
            for (int b = 0; b < DataWidth / 8; b++)
                if (a_mask[b]) mem[wr_idx][b*8 +: 8] <= a_data[b*8 +: 8];
        if (rd_en) rdata_q <= mem[rd_idx];
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            nlast_q     <= '0;
            base_q      <= '0;
            put_q       <= 1'b0;
            rdresp_q    <= 1'b0;
            d_valid_q   <= 1'b0;
            d_opcode_q  <= AccessAck;
            d_size_q    <= '0;
            d_source_q  <= '0;
            d_denied_q  <= 1'b0;
            d_corrupt_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (a_fire) begin
                    base_q      <= a_idx;
                    nlast_q     <= a_nlast;
                    put_q       <= a_put;
                    rdresp_q    <= a_get || a_atom;
                    d_size_q    <= a_size;
                    d_source_q  <= a_source;
                    d_denied_q  <= a_deny;
                    d_corrupt_q <= a_deny && (a_get || a_atom);
                    d_opcode_q  <= (a_get || a_atom) ? AccessAckData :
                                   a_intent          ? HintAck : AccessAck;
                    if ((a_put || a_atom) && (a_nlast != '0)) begin
                        cnt_q   <= CntW'(1);
                        state_q <= WRITE;
                    end else begin
                        cnt_q     <= '0;
                        d_valid_q <= 1'b1;
                        state_q   <= (a_get || a_atom) ? READ : RESP;
                    end
                end
                WRITE: if (a_fire) begin
                    if (last_beat) begin
                        cnt_q     <= '0;
                        d_valid_q <= 1'b1;
                        state_q   <= rdresp_q ? READ : RESP;
                    end else begin
                        cnt_q <= cnt_q + CntW'(1);
                    end
                end
                READ: if (d_fire) begin
                    if (last_beat) begin
                        cnt_q     <= '0;
                        d_valid_q <= 1'b0;
                        state_q   <= IDLE;
                    end else begin
                        cnt_q <= cnt_q + CntW'(1);
                    end
                end
                RESP: if (d_fire) begin
                    d_valid_q <= 1'b0;
                    state_q   <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign d_valid   = d_valid_q;
    assign d_opcode  = d_opcode_q;
    assign d_param   = 3'd0;
    assign d_size    = d_size_q;
    assign d_source  = d_source_q;
    assign d_sink    = '0;
    assign d_denied  = d_denied_q;
    assign d_corrupt = d_corrupt_q;
    assign d_data    = ((state_q == READ) && !d_denied_q) ? rdata_q : '0;

    logic unused_a;
    assign unused_a = ^{a_param, a_address};

    // Acquires have no meaning for a UH device; they fall through to the Intent path.
    assert property (@(posedge clk_i) disable iff (!rst_ni)
        a_fire |-> !(a_opcode inside {AcquireBlock, AcquirePerm}));
endmodule

// File: tb/tb_tl_ram_device.sv
// tb_tl_ram_device: random A-channel traffic against a beat-array reference model; D checked by a scoreboard monitor.
module tb_tl_ram_device;
    import tl_ram_device_pkg::*;

    localparam int NB = 1024;
`ifdef TL_RAM_DEVICE_ALIGN_CHECK_EN
    localparam bit ALIGN = 1'b1;
`else
    localparam bit ALIGN = 1'b0;
`endif

    logic clk_i = 1'b0;
    logic rst_ni = 1'b0;
    always #5 clk_i = ~clk_i;

    logic        a_valid = 1'b0, a_ready, a_corrupt = 1'b0;
    tl_a_op_e    a_opcode = PutFullData;
    logic [2:0]  a_param = 3'd0, a_size = 3'd0;
    logic [0:0]  a_source = 1'b0;
    logic [55:0] a_address = '0;
    logic [7:0]  a_mask = '0;
    logic [63:0] a_data = '0;
    logic        d_valid, d_ready = 1'b1, d_denied, d_corrupt;
    tl_d_op_e    d_opcode;
    logic [2:0]  d_param, d_size;
    logic [0:0]  d_source, d_sink;
    logic [63:0] d_data;

    tl_ram_device dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .a_valid(a_valid), .a_ready(a_ready), .a_opcode(a_opcode), .a_param(a_param),
        .a_size(a_size), .a_source(a_source), .a_address(a_address), .a_mask(a_mask),
        .a_corrupt(a_corrupt), .a_data(a_data),
        .d_valid(d_valid), .d_ready(d_ready), .d_opcode(d_opcode), .d_param(d_param),
        .d_size(d_size), .d_source(d_source), .d_sink(d_sink), .d_denied(d_denied),
        .d_corrupt(d_corrupt), .d_data(d_data)
    );

    typedef struct packed {
        logic [2:0]  op;
        logic [2:0]  size;
        logic        src;
        logic        den;
        logic        cor;
        logic [63:0] data;
    } rsp_t;

    rsp_t        expq[$];
    logic [63:0] mem_m [NB];
    logic [63:0] bd [16];
    logic [7:0]  bm [16];
    logic        bc [16];
    int total = 0, bad = 0;
    bit   drdy_rand = 1'b1;
    logic drdy_force = 1'b0;

    task automatic chk(string name, logic [127:0] got, logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    always @(posedge clk_i) begin
        #2;
        d_ready = drdy_rand ? ($urandom_range(0, 3) != 0) : drdy_force;
    end

    // Stalled beats are compared against the queue head each cycle; popped only on fire.
    always @(negedge clk_i) begin : monitor
        rsp_t g;
        if (rst_ni && d_valid) begin
            g.op   = d_opcode;
            g.size = d_size;
            g.src  = d_source;
            g.den  = d_denied;
            g.cor  = d_corrupt;
            g.data = (d_opcode == AccessAckData) ? d_data : 64'h0;
            chk("a_ready_during_d", a_ready, 1'b0);
            if (expq.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_d got=%h", g);
            end else begin
                chk("d_beat", g, expq[0]);
                chk("d_param_sink", {d_param, d_sink}, 4'h0);
                if (d_ready) void'(expq.pop_front());
            end
        end
    end

    // Model the request, then drive its A beats; caller must be at a negedge.
    task automatic issue(tl_a_op_e op, int sz, logic src, logic [55:0] addr);
        int  nb, na, idx, t;
        bit  den, isput, dat;
        rsp_t r;
        nb    = (sz > 3) ? (1 << (sz - 3)) : 1;
        idx   = int'(addr[12:3]);
        isput = (op == PutFullData) || (op == PutPartialData);
        dat   = isput || (op == ArithmeticData) || (op == LogicalData);
        den   = !(isput || op == Get) || (ALIGN && ((addr & ((56'd1 << sz) - 56'd1)) != 56'd0));
        na    = dat ? nb : 1;
        if (op == Get || op == ArithmeticData || op == LogicalData) begin
            for (int i = 0; i < nb; i++) begin
                r.op = AccessAckData; r.size = 3'(sz); r.src = src; r.den = den; r.cor = den;
                r.data = den ? 64'h0 : mem_m[(idx + i) % NB];
                expq.push_back(r);
            end
        end else begin
            r.op = (op == Intent) ? HintAck : AccessAck;
            r.size = 3'(sz); r.src = src; r.den = den; r.cor = 1'b0; r.data = 64'h0;
            expq.push_back(r);
        end
        if (isput && !den)
            for (int i = 0; i < nb; i++)
                if (!bc[i])
                    for (int b = 0; b < 8; b++)
                        if (bm[i][b]) mem_m[(idx + i) % NB][b*8 +: 8] = bd[i][b*8 +: 8];
        for (int i = 0; i < na; i++) begin
            a_valid = 1'b1; a_opcode = op; a_size = 3'(sz); a_source = src;
            a_address = addr; a_mask = bm[i]; a_data = bd[i]; a_corrupt = bc[i];
            a_param = 3'($urandom_range(0, 7));
            t = 0;
            while (!a_ready && t < 200) begin @(negedge clk_i); t++; end
            if (t >= 200) begin
                total++; bad++;
                $display("FAIL a_ready_timeout got=0 exp=1");
                a_valid = 1'b0;
                return;
            end
            @(posedge clk_i);
            @(negedge clk_i);
        end
        a_valid = 1'b0;
        chk("first_d_latency", d_valid, 1'b1);
    endtask

    task automatic drain();
        int t = 0;
        while (expq.size() != 0 && t < 500) begin @(negedge clk_i); t++; end
        if (expq.size() != 0) begin
            total++; bad++;
            $display("FAIL drain_timeout got=%0d_left exp=0", expq.size());
            expq.delete();
        end
    endtask

    task automatic fill_beats(bit rnd_mask, bit rnd_cor);
        for (int i = 0; i < 16; i++) begin
            bd[i] = {$urandom, $urandom};
            bm[i] = rnd_mask ? 8'($urandom) : 8'hFF;
            bc[i] = rnd_cor ? ($urandom_range(0, 7) == 0) : 1'b0;
        end
    endtask

    tl_a_op_e ops [6] = '{PutFullData, PutPartialData, ArithmeticData, LogicalData, Get, Intent};

    initial begin
        logic [55:0] addr;
        int sz;
        repeat (3) @(negedge clk_i);
        chk("reset_d_valid", d_valid, 1'b0);
        chk("reset_a_ready", a_ready, 1'b1);
        chk("reset_d_fields", {d_opcode, d_size, d_source, d_denied, d_corrupt}, 9'h0);
        rst_ni = 1'b1;
        @(negedge clk_i);

        // Initialise every RAM beat through full-size bursts.
        for (int k = 0; k < NB / 16; k++) begin
            fill_beats(1'b0, 1'b0);
            issue(PutFullData, 7, 1'b0, 56'(k * 128));
            drain();
        end

        fill_beats(1'b0, 1'b0);
        bd[0] = 64'h1122334455667788;
        issue(PutFullData, 3, 1'b1, 56'h40); drain();
        fill_beats(1'b0, 1'b0);
        issue(PutFullData, 5, 1'b0, 56'h40); drain();
        issue(Get, 5, 1'b1, 56'h40); drain();
        fill_beats(1'b0, 1'b0);
        bd[0] = 64'h1122334455667788;
        issue(PutFullData, 3, 1'b0, 56'h40); drain();
        bd[0] = 64'hFFFFFFFF_AAAAAAAA; bm[0] = 8'h0F;
        issue(PutPartialData, 3, 1'b1, 56'h40); drain();
        issue(Get, 3, 1'b0, 56'h40); drain();
        chk("partial_merge_model", mem_m[8], 64'h11223344AAAAAAAA);
        fill_beats(1'b0, 1'b0);
        issue(PutFullData, 4, 1'b1, 56'h1FF8); drain();
        issue(Get, 4, 1'b0, 56'h1FF8); drain();
        issue(Get, 3, 1'b1, 56'h0); drain();
        issue(LogicalData, 3, 1'b1, 56'h40); drain();
        issue(Get, 3, 1'b0, 56'h40); drain();
        issue(Get, 3, 1'b1, 56'h44); drain();
        issue(Intent, 2, 1'b0, 56'h80); drain();
        issue(ArithmeticData, 5, 1'b1, 56'h100); drain();

        for (int n = 0; n < 200; n++) begin
            sz   = $urandom_range(0, 7);
            addr = {$urandom, $urandom};
            if ($urandom_range(0, 1) == 1) addr = addr & ~((56'd1 << sz) - 56'd1);
            fill_beats(1'b1, 1'b1);
            issue(ops[$urandom_range(0, 5)], sz, 1'($urandom), addr);
            drain();
        end

        // Abort a stalled read burst with reset.
        drdy_rand = 1'b0; drdy_force = 1'b0;
        @(posedge clk_i); #3;
        @(negedge clk_i);
        issue(Get, 7, 1'b1, 56'h200);
        repeat (2) @(negedge clk_i);
        #2 rst_ni = 1'b0;
        #1 chk("reset_mid_read_d_valid", d_valid, 1'b0);
        expq.delete();
        @(negedge clk_i);
        rst_ni = 1'b1;
        drdy_rand = 1'b1;
        @(negedge clk_i);
        chk("a_ready_after_reset", a_ready, 1'b1);
        issue(Get, 3, 1'b0, 56'h40); drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
